// File: rtl/hc595_pkg.sv
// ---------------------------------------------------------------------------
// hc595_pkg
// Shared definitions for 74HC595 chain drivers.
//   STATE_*  : 2-bit encodings of the controller FSM states
//   state_t  : enumerated FSM state type built on those encodings
//   clog2    : ceiling log2 for sizing counters at elaboration time
// ---------------------------------------------------------------------------
package hc595_pkg;

  localparam logic [1:0] STATE_IDLE  = 2'd0;
  localparam logic [1:0] STATE_SHIFT = 2'd1;
  localparam logic [1:0] STATE_LATCH = 2'd2;

  typedef enum logic [1:0] {
    IDLE  = STATE_IDLE,
    SHIFT = STATE_SHIFT,
    LATCH = STATE_LATCH
  } state_t;

  // Smallest r with 2**r >= n; clog2(1) is 0.
  function automatic int clog2(input int n);
    int r;
    r = 0;
    while ((1 << r) < n) r++;
    return r;
  endfunction

endpackage

// File: rtl/hc595_tick_gen.sv
// ---------------------------------------------------------------------------
// hc595_tick_gen
// Phase timer that divides the system clock into DIV-cycle phases.
//   clk       : system clock
//   rst       : asynchronous active-high reset
//   restart   : holds the counter at the start of a phase
//   phase_end : high during the last cycle of each DIV-cycle phase
// ---------------------------------------------------------------------------
module hc595_tick_gen
  import hc595_pkg::*;
#(
  parameter int DIV = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic restart,
  output logic phase_end
);

  // A one-cycle phase still needs a 1-bit counter to keep the logic legal.
  localparam int CW = (clog2(DIV) > 0) ? clog2(DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(DIV - 1);

  logic [CW-1:0] cnt;

  assign phase_end = (cnt == LAST);

  // Counter reloads explicitly at the end of each phase so it never relies
  // on wrap-around, which would be wrong for non-power-of-two DIV.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt <= '0;
    end else if (restart || phase_end) begin
      cnt <= '0;
    end else begin
      cnt <= cnt + CW'(1);
    end
  end

endmodule

// File: rtl/hc595_chain_ctrl.sv
// ---------------------------------------------------------------------------
// hc595_chain_ctrl
// Serial controller for a daisy-chain of CHAIN_LEN 74HC595 devices. A frame
// is accepted over a valid/ready handshake, shifted out on DS/SHCP with a
// DIV-cycle half period, then latched with a DIV-cycle STCP pulse. OE stays
// inactive until the first complete frame has been latched.
//   clk     : system clock
//   rst     : asynchronous active-high reset
//   i_data  : frame to shift (W = 8*CHAIN_LEN bits), sampled on accept
//   i_valid : frame available
//   o_ready : controller idle and able to accept
//   o_ds    : serial data to the first device
//   o_shcp  : shift clock
//   o_stcp  : storage (latch) clock
//   o_oe    : output enable, active-low at the pin
// ---------------------------------------------------------------------------
module hc595_chain_ctrl
  import hc595_pkg::*;
#(
  parameter int CHAIN_LEN = 2,
  parameter int DIV       = 4,
  parameter int LSB_FIRST = 0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [8*CHAIN_LEN-1:0] i_data,
  input  logic                   i_valid,
  output logic                   o_ready,
  output logic                   o_ds,
  output logic                   o_shcp,
  output logic                   o_stcp,
  output logic                   o_oe
);

  localparam int W  = 8 * CHAIN_LEN;
  localparam int BW = clog2(W + 1);
  localparam logic [BW-1:0] LAST_BIT = BW'(W - 1);

  state_t         state, state_n;
  logic [W-1:0]   sr, sr_n, sr_shifted;
  logic [BW-1:0]  bit_cnt, bit_cnt_n;
  logic           ds_n, shcp_n, stcp_n, oe_n;
  logic           phase_end, restart;

  // Bit that sits at the output end of the shift register.
  function automatic logic out_bit(input logic [W-1:0] v);
    return (LSB_FIRST != 0) ? v[0] : v[W-1];
  endfunction

  hc595_tick_gen #(
    .DIV (DIV)
  ) u_tick (
    .clk       (clk),
    .rst       (rst),
    .restart   (restart),
    .phase_end (phase_end)
  );

  assign o_ready = (state == IDLE);

  // Next-state and next-output logic. The current SHCP level tells which
  // half of the bit we are in: low half ends by raising SHCP, high half
  // ends by dropping SHCP, shifting, and presenting the next bit on DS at
  // the same time so DS is stable for a whole phase on either side of the
  // rising edge. The phase timer is held in restart while idle so the first
  // low phase of a frame is a full DIV cycles long.
  always_comb begin
    state_n    = state;
    sr_n       = sr;
    bit_cnt_n  = bit_cnt;
    ds_n       = o_ds;
    shcp_n     = o_shcp;
    stcp_n     = o_stcp;
    oe_n       = o_oe;
    restart    = 1'b0;
    sr_shifted = (LSB_FIRST != 0) ? {1'b0, sr[W-1:1]} : {sr[W-2:0], 1'b0};

    case (state)
      IDLE: begin
        restart = 1'b1;
        if (i_valid) begin
          state_n   = SHIFT;
          sr_n      = i_data;
          bit_cnt_n = '0;
          ds_n      = out_bit(i_data);
          shcp_n    = 1'b0;
        end
      end

      SHIFT: begin
        if (phase_end) begin
          if (!o_shcp) begin
            shcp_n = 1'b1;
          end else begin
            shcp_n = 1'b0;
            sr_n   = sr_shifted;
            ds_n   = out_bit(sr_shifted);
            if (bit_cnt == LAST_BIT) begin
              state_n   = LATCH;
              bit_cnt_n = '0;
              stcp_n    = 1'b1;
            end else begin
              bit_cnt_n = bit_cnt + BW'(1);
            end
          end
        end
      end

      LATCH: begin
        if (phase_end) begin
          stcp_n  = 1'b0;
          oe_n    = 1'b0;
          state_n = IDLE;
        end
      end

      default: begin
        state_n = IDLE;
      end
    endcase
  end

  // State and datapath registers. Reset discards any partial frame and
  // re-blanks the outputs until a fresh frame has been latched.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state   <= IDLE;
      sr      <= '0;
      bit_cnt <= '0;
      o_ds    <= 1'b0;
      o_shcp  <= 1'b0;
      o_stcp  <= 1'b0;
      o_oe    <= 1'b1;
    end else begin
      state   <= state_n;
      sr      <= sr_n;
      bit_cnt <= bit_cnt_n;
      o_ds    <= ds_n;
      o_shcp  <= shcp_n;
      o_stcp  <= stcp_n;
      o_oe    <= oe_n;
    end
  end

endmodule
